booth_controller: RTL and testbench
===================================

# booth_controller

Sequencing FSM for the radix-2 Booth multiplier datapath. It accepts a start request, drives the partial-product register's load enable, then runs exactly WIDTH_IN evaluate/shift iterations. In each iteration it decodes the register's two LSBs into an add/subtract/no-op command. It finishes by presenting a result-valid handshake. It sits between the requester and the partial-product register plus adder/subtractor/shifter datapath, and holds no operand data itself.

## Interface
- WIDTH_IN, 16, multiplier/multiplicand width; iteration count; must be ≥ 2
- CNT_W, $clog2(WIDTH_IN), width of iteration counter
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- start_valid_i  in  1  requester has operands ready on datapath inputs
- start_ready_o  out  1  controller can accept a start (IDLE only)
- pp_lsb_i  in  2  partial product bits [1:0] = {Q0, Q-1}
- load_en_o  out  1  drives partial-product register load enable (loads {0, multiplier, 1'b0})
- alu_op_o  out  2  datapath command: NOP=00, ADD=01, SUB=10 (11 never driven)
- shift_en_o  out  1  datapath performs arithmetic shift right of partial product by 1
- busy_o  out  1  high in every state except IDLE
- iter_o  out  CNT_W  number of completed iterations in current operation
- result_valid_o  out  1  partial product holds final product
- result_ready_i  in  1  consumer accepts result

## Operation
- States: IDLE, LOAD, EVAL, SHIFT, DONE (encoding in package).
- IDLE: start_ready_o=1. The start handshake is start_valid_i & start_ready_o on a rising edge, and moves the FSM to LOAD. iter_o cleared to 0.
- LOAD: load_en_o=1 for exactly this cycle. Next state EVAL.
- EVAL: alu_op_o decoded from pp_lsb_i (01→ADD, 10→SUB, 00/11→NOP). This is the only Mealy output. The datapath writes the result into the upper half this cycle. EVAL is never skipped for NOP, so latency is fixed. Next state SHIFT.
- SHIFT: shift_en_o=1. iter_o increments on exit.
  - If iter_o == WIDTH_IN-1, the next state is DONE.
  - Otherwise the next state is EVAL.
- DONE: result_valid_o=1, held until result_ready_i=1 on an edge, then IDLE.
- In every state where they are not listed, alu_op_o=NOP and load_en_o/shift_en_o=0. The datapath therefore holds the partial product.
- Counter never wraps: max value WIDTH_IN-1 before DONE. It is held at WIDTH_IN-1 through DONE and cleared at the next accepted start.
- start_valid_i while busy: ignored, with no effect on state. The requester must keep it asserted until accepted.
- result_ready_i outside DONE: ignored.
- At most one of load_en_o, shift_en_o, (alu_op_o≠NOP) is active in any cycle.

## Timing
- Reset: on an edge with reset=0 → state IDLE, iter_o=0. Outputs from the next cycle:
  - start_ready_o=1
  - load_en_o=0, shift_en_o=0, busy_o=0, result_valid_o=0
  - alu_op_o=NOP
- Reset mid-operation (any state): same as above on that edge. The operation is aborted and no result_valid_o is produced.
- Accept on edge e0:
  - LOAD during cycle after e0.
  - EVAL for iteration k after edge e(1+2k); SHIFT after edge e(2+2k), k=0..WIDTH_IN-1.
  - DONE after edge e(2·WIDTH_IN+1): result_valid_o rises 33 cycles after the accept edge for WIDTH_IN=16.
- Earliest next accept: the edge after the DONE→IDLE edge. There is no overlap between operations.
- All outputs except alu_op_o are Moore, decoded from registered state. alu_op_o is combinational from state and pp_lsb_i.

## Structure
- Shared package booth_pkg:
  - state_t enum (IDLE, LOAD, EVAL, SHIFT, DONE)
  - alu_op_t enum (ALU_NOP=2'b00, ALU_ADD=2'b01, ALU_SUB=2'b10)
  - default WIDTH_IN constant
- One natural sub-module: booth_iter_counter, a CNT_W-bit counter with clear, increment and terminal-count flag (== WIDTH_IN-1), using synchronous active-low reset.
- The FSM and the op decode stay in booth_controller.

## Test plan
- Reset held low 2 cycles, start_valid_i=1 → no transition during reset. After release: start_ready_o=1, busy_o=0, iter_o=0, all commands idle. Accept occurs on the first edge after release.
- Single operation, WIDTH_IN=16, pp_lsb_i=2'b10 in every EVAL:
  - exactly one load_en_o cycle, the cycle after accept
  - 16 alu_op_o=SUB cycles alternating with 16 shift_en_o pulses
  - result_valid_o 33 cycles after accept
- Decode: drive pp_lsb_i 00, 01, 10, 11 in successive EVAL cycles → NOP, ADD, SUB, NOP. Toggling pp_lsb_i in IDLE/LOAD/SHIFT/DONE keeps alu_op_o=NOP.
- Backpressure: result_ready_i low for 5 cycles in DONE, with start_valid_i=1 throughout.
  - result_valid_o stays high, start_ready_o stays 0, no re-load.
  - After result_ready_i=1: IDLE on the next edge, then the new start is accepted on the following edge.
- Reset mid-op: reset=0 on the edge where iter_o=7 in SHIFT → IDLE, iter_o=0, result_valid_o never asserts for that operation.
- Integrated with partial-product register and adder, multiplicand 3, multiplier −5 (16'hFFFB) → after DONE, PP[32:1] = 32'hFFFF_FFF1 (−15). Second case: 16'h7FFF × 16'h7FFF → 32'h3FFF_0001.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier sequencer.
package booth_pkg;

  localparam int WIDTH_IN_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ALU_NOP = 2'b00,
    ALU_ADD = 2'b01,
    ALU_SUB = 2'b10
  } alu_op_t;

  // Booth recoding of {Q0, Q-1}: 01 adds the multiplicand, 10 subtracts it.
  function automatic alu_op_t decode_op(input logic [1:0] lsb);
    case (lsb)
      2'b01:   return ALU_ADD;
      2'b10:   return ALU_SUB;
      default: return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_controller_if.sv
// Requester handshake and datapath command bundle of the Booth sequencer.
interface booth_controller_if #(
  parameter int CNT_W = 4
);
  logic                  start_valid_i;
  logic                  start_ready_o;
  logic [1:0]            pp_lsb_i;
  logic                  load_en_o;
  booth_pkg::alu_op_t    alu_op_o;
  logic                  shift_en_o;
  logic                  busy_o;
  logic [CNT_W-1:0]      iter_o;
  logic                  result_valid_o;
  logic                  result_ready_i;

  // Controller side.
  modport slave (
    input  start_valid_i, pp_lsb_i, result_ready_i,
    output start_ready_o, load_en_o, alu_op_o, shift_en_o, busy_o,
           iter_o, result_valid_o
  );

  // Requester / datapath side.
  modport master (
    output start_valid_i, pp_lsb_i, result_ready_i,
    input  start_ready_o, load_en_o, alu_op_o, shift_en_o, busy_o,
           iter_o, result_valid_o
  );
endinterface

// File: rtl/booth_iter_counter.sv
// Iteration counter: clears on accept, counts completed shifts, saturates
// at the terminal count so it never wraps.
module booth_iter_counter #(
  parameter int WIDTH_IN = booth_pkg::WIDTH_IN_DEF,
  parameter int CNT_W    = $clog2(WIDTH_IN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  assign tc = (count == CNT_W'(WIDTH_IN - 1));

  // Count register with synchronous clear/increment; held at terminal count.
  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!reset)          count <= '0;
    else if (clr)        count <= '0;
    else if (inc && !tc) count <= count + 1'b1;
  end

endmodule

// File: rtl/booth_controller.sv
// Sequencing FSM for the radix-2 Booth multiplier datapath: load, then
// WIDTH_IN evaluate/shift iterations, then a result-valid handshake.
module booth_controller
  import booth_pkg::*;
#(
  parameter int WIDTH_IN = WIDTH_IN_DEF,
  parameter int CNT_W    = $clog2(WIDTH_IN)
) (
  input  logic                clk,
  input  logic                reset,
  booth_controller_if.slave   bus
);

  state_t state;
  logic   start_ready_q;
  logic   load_en_q;
  logic   shift_en_q;
  logic   busy_q;
  logic   result_valid_q;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   cnt_tc;

  assign cnt_clr = (state == IDLE) && bus.start_valid_i;
  assign cnt_inc = (state == SHIFT);

  booth_iter_counter #(
    .WIDTH_IN (WIDTH_IN),
    .CNT_W    (CNT_W)
  ) u_iter_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (bus.iter_o),
    .tc    (cnt_tc)
  );

  // State register; Moore outputs are registered alongside the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      start_ready_q  <= 1'b1;
      load_en_q      <= 1'b0;
      shift_en_q     <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid_i) begin
            state         <= LOAD;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            load_en_q     <= 1'b1;
          end
        end
        LOAD: begin
          state     <= EVAL;
          load_en_q <= 1'b0;
        end
        EVAL: begin
          state      <= SHIFT;
          shift_en_q <= 1'b1;
        end
        SHIFT: begin
          shift_en_q <= 1'b0;
          if (cnt_tc) begin
            state          <= DONE;
            result_valid_q <= 1'b1;
          end else begin
            state <= EVAL;
          end
        end
        DONE: begin
          if (bus.result_ready_i) begin
            state          <= IDLE;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            start_ready_q  <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          start_ready_q  <= 1'b1;
          load_en_q      <= 1'b0;
          shift_en_q     <= 1'b0;
          busy_q         <= 1'b0;
          result_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.start_ready_o  = start_ready_q;
  assign bus.load_en_o      = load_en_q;
  assign bus.shift_en_o     = shift_en_q;
  assign bus.busy_o         = busy_q;
  assign bus.result_valid_o = result_valid_q;

  // Only Mealy output: Booth command decoded live from the register LSBs.
  assign bus.alu_op_o = (state == EVAL) ? decode_op(bus.pp_lsb_i) : ALU_NOP;

endmodule

// File: tb/tb_booth_controller.sv
// Directed bench for booth_controller, with a small partial-product datapath
// model used for the end-to-end multiply cases.
module tb_booth_controller;
  import booth_pkg::*;

  localparam int WIDTH_IN = 16;
  localparam int CNT_W    = 4;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  booth_controller_if #(.CNT_W(CNT_W)) bif ();

  booth_controller #(.WIDTH_IN(WIDTH_IN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  // Partial-product register {A, Q, Q-1} driven by the controller commands.
  logic        use_dp;
  logic [1:0]  pp_lsb_drv;
  logic [32:0] pp;
  logic [15:0] mcand, mplier;

  assign bif.pp_lsb_i = use_dp ? pp[1:0] : pp_lsb_drv;

  always @(posedge clk) begin
    if (bif.load_en_o)                pp <= {16'd0, mplier, 1'b0};
    else if (bif.alu_op_o == ALU_ADD) pp[32:17] <= pp[32:17] + mcand;
    else if (bif.alu_op_o == ALU_SUB) pp[32:17] <= pp[32:17] - mcand;
    else if (bif.shift_en_o)          pp <= {pp[32], pp[32:1]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " start_ready"}, 32'(bif.start_ready_o), 32'd1);
    check({tag, " busy"},        32'(bif.busy_o),        32'd0);
    check({tag, " load_en"},     32'(bif.load_en_o),     32'd0);
    check({tag, " shift_en"},    32'(bif.shift_en_o),    32'd0);
    check({tag, " alu_op"},      32'(bif.alu_op_o),      32'(ALU_NOP));
    check({tag, " result_valid"},32'(bif.result_valid_o),32'd0);
  endtask

  initial begin
    int          loads, subs, shifts, alt_err, overlap, rv_cycle, rv_seen;
    bit          found;
    logic [1:0]  dec_in  [4];
    alu_op_t     dec_exp [4];

    use_dp             = 1'b0;
    pp_lsb_drv         = 2'b10;
    mcand              = '0;
    mplier             = '0;
    bif.start_valid_i  = 1'b1;
    bif.result_ready_i = 1'b0;
    reset              = 1'b0;

    // Reset held two cycles while a start is requested.
    tick();
    check_idle("rst1");
    tick();
    check_idle("rst2");
    reset = 1'b1;
    check("rst iter", 32'(bif.iter_o), 32'd0);

    // Accept on first edge after release.
    tick();
    bif.start_valid_i = 1'b0;
    check("acc load_en", 32'(bif.load_en_o), 32'd1);
    check("acc busy", 32'(bif.busy_o), 32'd1);
    check("acc start_ready", 32'(bif.start_ready_o), 32'd0);
    check("acc iter", 32'(bif.iter_o), 32'd0);

    // Full operation with SUB recoding every EVAL.
    loads = 1; subs = 0; shifts = 0; alt_err = 0; overlap = 0; rv_cycle = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bif.load_en_o) loads++;
      if (bif.alu_op_o == ALU_SUB) subs++;
      if (bif.shift_en_o) shifts++;
      if (32'(bif.load_en_o) + 32'(bif.shift_en_o) + 32'(bif.alu_op_o != ALU_NOP) > 1) overlap++;
      if (c <= 32) begin
        if ((c % 2) == 1 && !(bif.alu_op_o == ALU_SUB && !bif.shift_en_o)) alt_err++;
        if ((c % 2) == 0 && !(bif.alu_op_o == ALU_NOP && bif.shift_en_o)) alt_err++;
      end
      if (bif.result_valid_o) begin
        rv_cycle = c;
        break;
      end
    end
    check("op1 loads", 32'(loads), 32'd1);
    check("op1 subs", 32'(subs), 32'd16);
    check("op1 shifts", 32'(shifts), 32'd16);
    check("op1 alternation", 32'(alt_err), 32'd0);
    check("op1 overlap", 32'(overlap), 32'd0);
    check("op1 rv latency", 32'(rv_cycle), 32'd33);
    check("done iter", 32'(bif.iter_o), 32'd15);
    check("done alu nop", 32'(bif.alu_op_o), 32'(ALU_NOP));

    // Backpressure in DONE with a pending start.
    bif.start_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pp_lsb_drv = 2'(i);
      tick();
      check("bp result_valid", 32'(bif.result_valid_o), 32'd1);
      check("bp start_ready", 32'(bif.start_ready_o), 32'd0);
      check("bp load_en", 32'(bif.load_en_o), 32'd0);
      check("bp alu nop", 32'(bif.alu_op_o), 32'(ALU_NOP));
    end
    bif.result_ready_i = 1'b1;
    tick();
    bif.result_ready_i = 1'b0;
    check_idle("release");
    tick();
    bif.start_valid_i = 1'b0;
    check("op2 load_en", 32'(bif.load_en_o), 32'd1);
    check("op2 iter clear", 32'(bif.iter_o), 32'd0);

    // Decode: LOAD ignores LSBs, then four EVALs with distinct patterns.
    pp_lsb_drv = 2'b01;
    #1;
    check("load alu nop", 32'(bif.alu_op_o), 32'(ALU_NOP));
    dec_in  = '{2'b00, 2'b01, 2'b10, 2'b11};
    dec_exp = '{ALU_NOP, ALU_ADD, ALU_SUB, ALU_NOP};
    for (int i = 0; i < 4; i++) begin
      tick();
      pp_lsb_drv = dec_in[i];
      #1;
      check("eval decode", 32'(bif.alu_op_o), 32'(dec_exp[i]));
      tick();
      pp_lsb_drv = 2'b10;
      #1;
      check("shift alu nop", 32'(bif.alu_op_o), 32'(ALU_NOP));
    end

    // Advance to SHIFT with iter 7, then reset on that edge.
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bif.shift_en_o && bif.iter_o == 4'd7) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("reach iter7", 32'(found), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_idle("midrst");
    check("midrst iter", 32'(bif.iter_o), 32'd0);
    rv_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bif.result_valid_o || bif.busy_o) rv_seen++;
    end
    check("aborted no result", 32'(rv_seen), 32'd0);

    // End-to-end multiplies through the datapath model.
    use_dp = 1'b1;
    mcand  = 16'd3;
    mplier = 16'hFFFB;
    bif.start_valid_i = 1'b1;
    tick();
    bif.start_valid_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bif.result_valid_o) begin
        found = 1'b1;
        break;
      end
    end
    check("mul1 done", 32'(found), 32'd1);
    check("mul1 3*-5", pp[32:1], 32'hFFFF_FFF1);
    bif.result_ready_i = 1'b1;
    tick();
    bif.result_ready_i = 1'b0;

    mcand  = 16'h7FFF;
    mplier = 16'h7FFF;
    bif.start_valid_i = 1'b1;
    tick();
    bif.start_valid_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bif.result_valid_o) begin
        found = 1'b1;
        break;
      end
    end
    check("mul2 done", 32'(found), 32'd1);
    check("mul2 7fff^2", pp[32:1], 32'h3FFF_0001);
    bif.result_ready_i = 1'b1;
    tick();
    bif.result_ready_i = 1'b0;
    check_idle("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
